// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester register-file write arbiter, each requester with a
// one-entry holding buffer and a registered write port to the register file.
//
// Parameters:
//   DATA_WIDTH    register data width
//   ADDR_WIDTH    register address width (2**ADDR_WIDTH registers)
//
// Ports:
//   CLK           clock, all state updates on posedge
//   RST           synchronous active-high reset
//   Req0_Valid    requester 0 (ALU writeback) offers a write
//   Req0_Address  requester 0 target register
//   Req0_Data     requester 0 write data
//   Req0_Ready    requester 0 offer is accepted this edge if Req0_Valid is high
//   Req1_Valid    requester 1 (load path) offers a write
//   Req1_Address  requester 1 target register
//   Req1_Data     requester 1 write data
//   Req1_Ready    requester 1 offer is accepted this edge if Req1_Valid is high
//   WriteEN       registered register-file write enable
//   Write_Address registered register-file write address
//   Write_Data    registered register-file write data
//   Busy          per-register mask of pending writes (buffered or on the write port)
//   Grant         index of the requester granted most recently
//
// Configuration macro:
//   REGFILE_WRARB_ROUND_ROBIN_EN  when defined, contested cycles alternate between the two
//                                 requesters; otherwise requester 0 always wins.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Req0_Valid,
    input  logic [ADDR_WIDTH-1:0]      Req0_Address,
    input  logic [DATA_WIDTH-1:0]      Req0_Data,
    output logic                       Req0_Ready,
    input  logic                       Req1_Valid,
    input  logic [ADDR_WIDTH-1:0]      Req1_Address,
    input  logic [DATA_WIDTH-1:0]      Req1_Data,
    output logic                       Req1_Ready,
    output logic                       WriteEN,
    output logic [ADDR_WIDTH-1:0]      Write_Address,
    output logic [DATA_WIDTH-1:0]      Write_Data,
    output logic [2**ADDR_WIDTH-1:0]   Busy,
    output logic                       Grant
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    // Holding buffers
    logic                  buf0_valid;
    logic [ADDR_WIDTH-1:0] buf0_addr;
    logic [DATA_WIDTH-1:0] buf0_data;
    logic                  buf1_valid;
    logic [ADDR_WIDTH-1:0] buf1_addr;
    logic [DATA_WIDTH-1:0] buf1_data;

    // Registered write port
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  grant_q;

    // Arbitration and handshake
    logic win0;
    logic win1;
    logic take0;
    logic take1;

    // Winner is a function of registered state only, so Ready never
    // depends on the requester's own Valid.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        unique case ({buf0_valid, buf1_valid})
            2'b10: win0 = 1'b1;
            2'b01: win1 = 1'b1;
            2'b11: begin
`ifdef REGFILE_WRARB_ROUND_ROBIN_EN
                // Serve whichever requester was not granted last time.
                if (grant_q) begin
                    win0 = 1'b1;
                end else begin
                    win1 = 1'b1;
                end
`else
                win0 = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // A full buffer can still accept when it is draining this edge,
    // which gives a lone requester one transfer per cycle.
    assign Req0_Ready = (~buf0_valid | win0) & ~RST;
    assign Req1_Ready = (~buf1_valid | win1) & ~RST;

    assign take0 = Req0_Valid & Req0_Ready;
    assign take1 = Req1_Valid & Req1_Ready;

    // Requester 0 holding buffer
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf0_valid <= 1'b0;
            buf0_addr  <= '0;
            buf0_data  <= '0;
        end else if (take0) begin
            buf0_valid <= 1'b1;
            buf0_addr  <= Req0_Address;
            buf0_data  <= Req0_Data;
        end else if (win0) begin
            buf0_valid <= 1'b0;
        end
    end

    // Requester 1 holding buffer
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf1_valid <= 1'b0;
            buf1_addr  <= '0;
            buf1_data  <= '0;
        end else if (take1) begin
            buf1_valid <= 1'b1;
            buf1_addr  <= Req1_Address;
            buf1_data  <= Req1_Data;
        end else if (win1) begin
            buf1_valid <= 1'b0;
        end
    end

    // Write port: address/data/grant only move on a grant.
    // Grant resets to 1 so the first contested cycle goes to requester 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            grant_q   <= 1'b1;
        end else if (win0) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= buf0_addr;
            wr_data_q <= buf0_data;
            grant_q   <= 1'b0;
        end else if (win1) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= buf1_addr;
            wr_data_q <= buf1_data;
            grant_q   <= 1'b1;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    // Pending-write mask: both buffers plus the write port in flight.
    always_comb begin
        Busy = '0;
        if (buf0_valid) begin
            Busy = Busy | (NUM_REGS'(1) << buf0_addr);
        end
        if (buf1_valid) begin
            Busy = Busy | (NUM_REGS'(1) << buf1_addr);
        end
        if (wr_en_q) begin
            Busy = Busy | (NUM_REGS'(1) << wr_addr_q);
        end
    end

    assign WriteEN       = wr_en_q;
    assign Write_Address = wr_addr_q;
    assign Write_Data    = wr_data_q;
    assign Grant         = grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus against a queue-based
// reference model of the write arbiter; register-file contents compared at the end.
module tb_regfile_write_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;
`ifdef REGFILE_WRARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic          Req0_Valid;
    logic [AW-1:0] Req0_Address;
    logic [DW-1:0] Req0_Data;
    logic          Req0_Ready;
    logic          Req1_Valid;
    logic [AW-1:0] Req1_Address;
    logic [DW-1:0] Req1_Data;
    logic          Req1_Ready;
    logic          WriteEN;
    logic [AW-1:0] Write_Address;
    logic [DW-1:0] Write_Data;
    logic [NR-1:0] Busy;
    logic          Grant;

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Req0_Valid   (Req0_Valid),
        .Req0_Address (Req0_Address),
        .Req0_Data    (Req0_Data),
        .Req0_Ready   (Req0_Ready),
        .Req1_Valid   (Req1_Valid),
        .Req1_Address (Req1_Address),
        .Req1_Data    (Req1_Data),
        .Req1_Ready   (Req1_Ready),
        .WriteEN      (WriteEN),
        .Write_Address(Write_Address),
        .Write_Data   (Write_Data),
        .Busy         (Busy),
        .Grant        (Grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: each requester's pending write is a queue entry {addr,data}.
    logic [AW+DW-1:0] q0[$];
    logic [AW+DW-1:0] q1[$];
    bit               m_we;
    logic [AW-1:0]    m_wa;
    logic [DW-1:0]    m_wd;
    bit               m_g;
    logic [DW-1:0]    rf_m[NR];
    logic [DW-1:0]    rf_d[NR];

    function automatic int m_winner();
        if (q0.size() != 0 && q1.size() != 0) begin
            if (RR) return m_g ? 0 : 1;
            return 0;
        end
        if (q0.size() != 0) return 0;
        if (q1.size() != 0) return 1;
        return -1;
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] b;
        b = '0;
        foreach (q0[i]) b[q0[i][AW+DW-1:DW]] = 1'b1;
        foreach (q1[i]) b[q1[i][AW+DW-1:DW]] = 1'b1;
        if (m_we) b[m_wa] = 1'b1;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, clock, check registered outputs.
    task automatic step(input bit rst,
                        input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int w;
        bit r0;
        bit r1;
        logic [AW+DW-1:0] e;
        RST = rst;
        Req0_Valid = v0; Req0_Address = a0; Req0_Data = d0;
        Req1_Valid = v1; Req1_Address = a1; Req1_Data = d1;
        #1;
        w  = m_winner();
        r0 = !rst && (q0.size() == 0 || w == 0);
        r1 = !rst && (q1.size() == 0 || w == 1);
        check("ready0", 32'(Req0_Ready), 32'(r0));
        check("ready1", 32'(Req1_Ready), 32'(r1));
        check("busy", 32'(Busy), 32'(m_busy()));
        @(posedge CLK);
        if (rst) begin
            q0.delete(); q1.delete();
            m_we = 0; m_wa = '0; m_wd = '0; m_g = 1;
        end else begin
            if (w == 0) begin
                e = q0.pop_front();
                m_we = 1; {m_wa, m_wd} = e; m_g = 0;
            end else if (w == 1) begin
                e = q1.pop_front();
                m_we = 1; {m_wa, m_wd} = e; m_g = 1;
            end else begin
                m_we = 0;
            end
            if (v0 && r0) q0.push_back({a0, d0});
            if (v1 && r1) q1.push_back({a1, d1});
        end
        if (m_we) rf_m[m_wa] = m_wd;
        #1;
        check("write_en", 32'(WriteEN), 32'(m_we));
        check("write_addr", 32'(Write_Address), 32'(m_wa));
        check("write_data", 32'(Write_Data), 32'(m_wd));
        check("grant", 32'(Grant), 32'(m_g));
        if (WriteEN === 1'b1) rf_d[Write_Address] = Write_Data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            rf_m[i] = '0;
            rf_d[i] = '0;
        end
        RST = 1'b1;
        Req0_Valid = 0; Req0_Address = '0; Req0_Data = '0;
        Req1_Valid = 0; Req1_Address = '0; Req1_Data = '0;
        repeat (2) @(posedge CLK);
        #1;
        m_we = 0; m_wa = '0; m_wd = '0; m_g = 1;
        check("rst_we", 32'(WriteEN), 32'h0);
        check("rst_grant", 32'(Grant), 32'h1);
        check("rst_busy", 32'(Busy), 32'h0);
        step(1, 1, 3'd1, 8'hAA, 1, 3'd2, 8'hBB);

        // Single write, addr 3 data 0x5A
        step(0, 1, 3'd3, 8'h5A, 0, '0, '0);
        check("s1_busy_pending", 32'(Busy), 32'h08);
        idle(1);
        check("s1_we", 32'(WriteEN), 32'h1);
        check("s1_addr", 32'(Write_Address), 32'h3);
        check("s1_data", 32'(Write_Data), 32'h5A);
        check("s1_busy_inflight", 32'(Busy), 32'h08);
        idle(1);
        check("s1_busy_clear", 32'(Busy), 32'h00);
        check("s1_we_off", 32'(WriteEN), 32'h0);

        // Continuous contention, addrs 1 and 2
        step(1, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 3'd1, DW'($urandom), 1, 3'd2, DW'($urandom));
            if (i == 1) check("cont_w1", 32'(Write_Address), 32'h1);
            if (i == 2) check("cont_w2", 32'(Write_Address), RR ? 32'h2 : 32'h1);
            if (i == 3) check("cont_w3", 32'(Write_Address), 32'h1);
        end
        idle(4);

        // Same address from both requesters right after reset
        step(1, 0, '0, '0, 0, '0, '0);
        step(0, 1, 3'd5, 8'h11, 1, 3'd5, 8'h22);
        idle(1);
        check("same_first", 32'(Write_Data), 32'h11);
        check("same_busy_mid", 32'(Busy[5]), 32'h1);
        idle(1);
        check("same_second", 32'(Write_Data), 32'h22);
        check("same_busy_last", 32'(Busy[5]), 32'h1);
        idle(1);
        check("same_busy_done", 32'(Busy[5]), 32'h0);
        check("same_rf", 32'(rf_d[5]), 32'h22);

        // Lone requester 1 streaming 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, '0, '0, 1, AW'($urandom), DW'(i));
            if (i >= 2) check("stream_data", 32'(Write_Data), 32'(i - 1));
        end
        idle(1);
        check("stream_last", 32'(Write_Data), 32'h08);
        idle(1);

        // Reset with both buffers full
        step(0, 1, 3'd6, 8'h66, 1, 3'd7, 8'h77);
        step(1, 1, 3'd6, 8'h67, 1, 3'd7, 8'h78);
        check("rstmid_we", 32'(WriteEN), 32'h0);
        check("rstmid_grant", 32'(Grant), 32'h1);
        idle(1);
        check("rstmid_we_after", 32'(WriteEN), 32'h0);
        check("rstmid_busy", 32'(Busy), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 6), AW'($urandom), DW'($urandom),
                 ($urandom_range(0, 9) < 6), AW'($urandom), DW'($urandom));
        end
        idle(4);

        for (int i = 0; i < NR; i++) check("regfile", 32'(rf_d[i]), 32'(rf_m[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
